// File: rtl/hybrid_adder_circuit_pkg.sv
// Shared constants for the hybrid 8-bit adder: overall width and the
// bit positions where the ripple/lookahead/ripple segments meet.
package hybrid_adder_circuit_pkg;
  localparam int WIDTH   = 8;
  localparam int CLA_LO  = 2;
  localparam int CLA_HI  = 5;

  typedef struct packed {
    logic       c8;
    logic [7:0] s;
  } add_result_t;
endpackage

// File: rtl/hybrid_adder_circuit_if.sv
// Signal bundle for the adder's operand and result buses; the master drives
// operands and observes the registered result.
interface hybrid_adder_circuit_if
  import hybrid_adder_circuit_pkg::*;
  ();
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             C0;
  logic [WIDTH-1:0] S;
  logic             C8;

  modport master (output X, Y, C0, input S, C8);
  modport slave  (input X, Y, C0, output S, C8);
endinterface

// File: rtl/hybrid_adder_circuit_full_adder.sv
// Single-bit full adder used as the cell of both ripple-carry segments.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_p;
  logic w_g;

  assign w_p  = a ^ b;
  assign w_g  = a & b;
  assign s    = w_p ^ cin;
  assign cout = w_g | (w_p & cin);
endmodule

// File: rtl/hybrid_adder_circuit.sv
// 8-bit adder with a 2-bit ripple / 3-bit lookahead / 3-bit ripple carry chain,
// result registered once with an asynchronous active-low clear.
module hybrid_adder_circuit
  import hybrid_adder_circuit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] S,
  output logic             C8,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C0
);
  logic [WIDTH:0]      w_c;
  logic [WIDTH-1:0]    w_sum;
  logic [CLA_HI-1:CLA_LO] w_g;
  logic [CLA_HI-1:CLA_LO] w_p;
  add_result_t         r_result;

  assign w_c[0] = C0;

  for (genvar i = 0; i < CLA_LO; i++) begin : g_ripple_lo
    full_adder u_fa (
      .a    (X[i]),
      .b    (Y[i]),
      .cin  (w_c[i]),
      .s    (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  // Lookahead carries all flatten back to c2 so c3..c5 settle in parallel.
  assign w_g = X[CLA_HI-1:CLA_LO] & Y[CLA_HI-1:CLA_LO];
  assign w_p = X[CLA_HI-1:CLA_LO] ^ Y[CLA_HI-1:CLA_LO];

  assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_c[2]);
  assign w_c[5] = w_g[4] | (w_p[4] & w_g[3]) | (w_p[4] & w_p[3] & w_g[2])
                | (w_p[4] & w_p[3] & w_p[2] & w_c[2]);

  assign w_sum[CLA_HI-1:CLA_LO] = w_p ^ w_c[CLA_HI-1:CLA_LO];

  for (genvar i = CLA_HI; i < WIDTH; i++) begin : g_ripple_hi
    full_adder u_fa (
      .a    (X[i]),
      .b    (Y[i]),
      .cin  (w_c[i]),
      .s    (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else begin
      r_result <= {w_c[WIDTH], w_sum};
    end
  end

  assign S  = r_result.s;
  assign C8 = r_result.c8;
endmodule

// File: tb/tb_hybrid_adder_circuit.sv
// Self-checking bench for hybrid_adder_circuit: directed corner vectors, pipelining,
// asynchronous reset and random operands against a plain X+Y+C0 reference.
module tb_hybrid_adder_circuit;
  logic clk;
  logic rst_n;
  int   nChecks;
  int   nPassed;

  hybrid_adder_circuit_if hif ();

  hybrid_adder_circuit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .S     (hif.S),
    .C8    (hif.C8),
    .X     (hif.X),
    .Y     (hif.Y),
    .C0    (hif.C0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] refSum(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned total;
    total = int'(x) + int'(y) + int'(c);
    return total[8:0];
  endfunction

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    hif.X  = x;
    hif.Y  = y;
    hif.C0 = c;
  endtask

  task automatic test_reset();
    hif.X  = 8'hFF;
    hif.Y  = 8'hFF;
    hif.C0 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h000)
      $display("[TB] FAIL reset_async: got C8=%b S=%h, expected C8=0 S=00", hif.C8, hif.S);
    else nPassed++;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h000)
      $display("[TB] FAIL reset_hold: got C8=%b S=%h, expected C8=0 S=00", hif.C8, hif.S);
    else nPassed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h1FF)
      $display("[TB] FAIL reset_release: got C8=%b S=%h, expected C8=1 S=FF", hif.C8, hif.S);
    else nPassed++;
  endtask

  task automatic test_directed();
    logic [7:0] xs [8] = '{8'h60, 8'hFF, 8'hAA, 8'hAA, 8'h08, 8'h08, 8'h01, 8'hF0};
    logic [7:0] ys [8] = '{8'h7F, 8'hFE, 8'h55, 8'h55, 8'h81, 8'h81, 8'h00, 8'h88};
    logic       cs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [8:0] want [8] = '{9'h0DF, 9'h1FD, 9'h0FF, 9'h100, 9'h089, 9'h08A, 9'h002, 9'h179};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(xs[i], ys[i], cs[i]);
      @(posedge clk);
      #1;
      nChecks++;
      if ({hif.C8, hif.S} !== want[i])
        $display("[TB] FAIL directed_%0d: X=%h Y=%h C0=%b got C8=%b S=%h, expected C8=%b S=%h",
                 i, xs[i], ys[i], cs[i], hif.C8, hif.S, want[i][8], want[i][7:0]);
      else nPassed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, y;
    logic       c;
    logic [8:0] prev;
    logic [8:0] nowExp;
    prev = {hif.C8, hif.S};
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      nowExp = refSum(x, y, c);
      applyStimulus(x, y, c);
      #1;
      nChecks++;
      if ({hif.C8, hif.S} !== prev)
        $display("[TB] FAIL b2b_hold_%0d: got C8=%b S=%h, expected C8=%b S=%h",
                 i, hif.C8, hif.S, prev[8], prev[7:0]);
      else nPassed++;
      @(posedge clk);
      #1;
      nChecks++;
      if ({hif.C8, hif.S} !== nowExp)
        $display("[TB] FAIL b2b_result_%0d: got C8=%b S=%h, expected C8=%b S=%h",
                 i, hif.C8, hif.S, nowExp[8], nowExp[7:0]);
      else nPassed++;
      prev = nowExp;
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h1FF)
      $display("[TB] FAIL mid_before: got C8=%b S=%h, expected C8=1 S=FF", hif.C8, hif.S);
    else nPassed++;
    applyStimulus(8'h12, 8'h34, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h000)
      $display("[TB] FAIL mid_async_clear: got C8=%b S=%h, expected C8=0 S=00", hif.C8, hif.S);
    else nPassed++;
    @(posedge clk);
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h000)
      $display("[TB] FAIL mid_discard: got C8=%b S=%h, expected C8=0 S=00", hif.C8, hif.S);
    else nPassed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nChecks++;
    if ({hif.C8, hif.S} !== 9'h047)
      $display("[TB] FAIL mid_release: got C8=%b S=%h, expected C8=0 S=47", hif.C8, hif.S);
    else nPassed++;
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    logic       c;
    logic [8:0] want;
    int         errs;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      want = refSum(x, y, c);
      applyStimulus(x, y, c);
      @(posedge clk);
      #1;
      nChecks++;
      if ({hif.C8, hif.S} !== want) begin
        errs++;
        if (errs <= 10)
          $display("[TB] FAIL random_%0d: X=%h Y=%h C0=%b got C8=%b S=%h, expected C8=%b S=%h",
                   i, x, y, c, hif.C8, hif.S, want[8], want[7:0]);
      end else nPassed++;
    end
  endtask

  initial begin
    nChecks = 0;
    nPassed = 0;
    rst_n   = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end
endmodule
